// File: rtl/qpmm_issue_arbiter.sv
// Round-robin issue scheduler sharing one fixed-latency QPMM multiplier.
// Tags ride alongside the multiplier pipe to steer each result home.
module qpmm_issue_arbiter #(
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 40,
  parameter int MAX_OUT = 8,
  parameter int FW      = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ-1:0][FW-1:0]  req_a,
  input  logic [NREQ-1:0][FW-1:0]  req_b,
  output logic [FW-1:0]            mul_a,
  output logic [FW-1:0]            mul_b,
  input  logic [FW-1:0]            mul_z,
  output logic [NREQ-1:0]          res_valid,
  output logic [FW-1:0]            res_z,
  output logic                     busy
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = 4;

  typedef logic [IW-1:0] id_t;

  logic [IW-1:0]  ptr;
  logic [CW-1:0]  cnt [NREQ];
  logic [NREQ-1:0] elig;
  logic           go;
  id_t            g;
  logic [IW:0]    idx;
  logic [MUL_LAT:0] tv;
  id_t            tid [MUL_LAT+1];

  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++)
      elig[i] = req_valid[i] && (cnt[i] < CW'(MAX_OUT));
  end

  // Scan downward so the candidate nearest ptr wins last.
  always_comb begin
    go  = 1'b0;
    g   = '0;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + (IW+1)'(k);
      if (idx >= (IW+1)'(NREQ))
        idx = idx - (IW+1)'(NREQ);
      if (elig[idx[IW-1:0]]) begin
        go = 1'b1;
        g  = idx[IW-1:0];
      end
    end
    if (rst)
      go = 1'b0;
  end

  always_comb begin
    req_ready = '0;
    if (go)
      req_ready[g] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      tv        <= '0;
      res_valid <= '0;
      res_z     <= '0;
      for (int k = 0; k <= MUL_LAT; k++)
        tid[k] <= '0;
    end else begin
      if (go) begin
        ptr   <= (g == id_t'(NREQ - 1)) ? '0 : g + id_t'(1);
        mul_a <= req_a[g];
        mul_b <= req_b[g];
      end
      tv     <= {tv[MUL_LAT-1:0], go};
      tid[0] <= g;
      for (int k = 1; k <= MUL_LAT; k++)
        tid[k] <= tid[k-1];
      res_valid <= '0;
      if (tv[MUL_LAT]) begin
        res_valid[tid[MUL_LAT]] <= 1'b1;
        res_z                   <= mul_z;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++)
        cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        case ({go && (g == id_t'(i)), res_valid[i]})
          2'b10:   cnt[i] <= cnt[i] + CW'(1);
          2'b01:   cnt[i] <= cnt[i] - CW'(1);
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

  always_comb begin
    busy = |tv;
    for (int i = 0; i < NREQ; i++)
      if (cnt[i] != '0)
        busy = 1'b1;
  end

endmodule

// File: tb/tb_qpmm_issue_arbiter.sv
// Bench for qpmm_issue_arbiter: pipelined multiplier model plus
// a scoreboard predicting result id, value and arrival cycle.
module tb_qpmm_issue_arbiter;

  localparam int NREQ    = 4;
  localparam int MUL_LAT = 40;
  localparam int MAX_OUT = 8;
  localparam int FW      = 256;
  localparam int LAT     = MUL_LAT + 2;

  typedef struct {
    int cyc;
    int id;
    logic [FW-1:0] z;
  } exp_t;

  typedef struct {
    int cyc;
    int id;
  } ev_t;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [NREQ-1:0]         req_valid = '0;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ-1:0][FW-1:0] req_a = '0;
  logic [NREQ-1:0][FW-1:0] req_b = '0;
  logic [FW-1:0]           mul_a;
  logic [FW-1:0]           mul_b;
  logic [FW-1:0]           mul_z;
  logic [NREQ-1:0]         res_valid;
  logic [FW-1:0]           res_z;
  logic                    busy;

  qpmm_issue_arbiter #(
    .NREQ(NREQ), .MUL_LAT(MUL_LAT), .MAX_OUT(MAX_OUT), .FW(FW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_z(mul_z),
    .res_valid(res_valid), .res_z(res_z), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [FW-1:0] pipe [MUL_LAT];
  always @(posedge clk) begin
    pipe[0] <= mul_a * mul_b;
    for (int k = 1; k < MUL_LAT; k++)
      pipe[k] <= pipe[k-1];
  end
  assign mul_z = pipe[MUL_LAT-1];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [FW-1:0] got,
                       input logic [FW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  exp_t sb[$];
  ev_t  tx_log[$];
  ev_t  rs_log[$];
  int   mcnt [NREQ];
  int   mptr = 0;
  logic [NREQ-1:0] last_tx = '0;
  logic [NREQ-1:0] one_shot = '0;
  logic post_rst = 1'b0;

  initial begin
    for (int i = 0; i < NREQ; i++) mcnt[i] = 0;
    forever begin
      @(negedge clk);
      last_tx = '0;
      if (rst) begin
        check("rst_ready", req_ready, '0);
        sb.delete();
        for (int i = 0; i < NREQ; i++) mcnt[i] = 0;
        mptr = 0;
        post_rst = 1'b1;
      end else begin
        logic [NREQ-1:0] expg;
        logic [NREQ-1:0] oh;
        logic any;
        exp_t e;
        ev_t  ev;
        if (post_rst) begin
          check("rst_mul_a", mul_a, '0);
          check("rst_mul_b", mul_b, '0);
          check("rst_res_z", res_z, '0);
          check("rst_res_valid", res_valid, '0);
          check("rst_busy", busy, '0);
          post_rst = 1'b0;
        end
        expg = '0;
        for (int k = 0; k < NREQ; k++) begin
          int j;
          j = (mptr + k) % NREQ;
          if (expg == '0 && req_valid[j] && mcnt[j] < MAX_OUT)
            expg[j] = 1'b1;
        end
        check("grant", req_ready, expg);
        any = 1'b0;
        for (int i = 0; i < NREQ; i++)
          if (mcnt[i] != 0) any = 1'b1;
        check("busy", busy, any);
        if (res_valid != '0) begin
          if (sb.size() == 0) begin
            check("res_spurious", res_valid, '0);
          end else begin
            e = sb.pop_front();
            oh = '0;
            oh[e.id] = 1'b1;
            check("res_id", res_valid, oh);
            check("res_z", res_z, e.z);
            check("res_cycle", cyc, e.cyc);
            mcnt[e.id]--;
          end
          for (int i = 0; i < NREQ; i++)
            if (res_valid[i]) begin
              ev.cyc = cyc;
              ev.id = i;
              rs_log.push_back(ev);
            end
        end
        for (int i = 0; i < NREQ; i++)
          if (req_valid[i] && req_ready[i]) begin
            e.cyc = cyc + LAT;
            e.id  = i;
            e.z   = req_a[i] * req_b[i];
            sb.push_back(e);
            mcnt[i]++;
            mptr = (i + 1) % NREQ;
            last_tx[i] = 1'b1;
            ev.cyc = cyc;
            ev.id = i;
            tx_log.push_back(ev);
          end
      end
    end
  end

  task automatic new_ops(input int i);
    req_a[i] = FW'({$urandom, $urandom});
    req_b[i] = FW'({$urandom, $urandom});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++)
      if (last_tx[i]) begin
        new_ops(i);
        if (one_shot[i]) req_valid[i] = 1'b0;
      end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    req_valid = '0;
    one_shot = '0;
    step();
    step();
    rst = 1'b0;
    tx_log.delete();
    rs_log.delete();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 400) begin
      step();
      n++;
    end
    check("drain_timeout", n < 400, 1'b1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int c0;
    int acyc[$];
    int n0;
    int n3;
    for (int i = 0; i < NREQ; i++) new_ops(i);

    // single op from requester 2
    do_reset();
    req_a[2] = FW'(3);
    req_b[2] = FW'(5);
    req_valid[2] = 1'b1;
    step();
    req_valid = '0;
    check("s1_grant", last_tx, 4'b0100);
    check("s1_busy", busy, 1'b1);
    drain();
    check("s1_res_n", rs_log.size(), 1);
    if (rs_log.size() == 1)
      check("s1_lat", rs_log[0].cyc - tx_log[0].cyc, LAT);

    // full contention
    do_reset();
    req_valid = '1;
    c0 = cyc;
    for (int k = 0; k < 60; k++) step();
    req_valid = '0;
    check("s2_tx_n", tx_log.size() >= 32, 1'b1);
    if (tx_log.size() >= 32) begin
      check("s2_first", tx_log[0].cyc, c0);
      for (int k = 0; k < 32; k++) begin
        check("s2_order", tx_log[k].id, k % NREQ);
        check("s2_cyc", tx_log[k].cyc, c0 + k);
      end
    end
    drain();
    check("s2_res_n", rs_log.size(), tx_log.size());
    if (rs_log.size() > 4)
      for (int k = 0; k < 4; k++)
        check("s2_res_order", rs_log[k].id, k);

    // cap on a single requester
    do_reset();
    req_valid[1] = 1'b1;
    for (int k = 0; k < 50; k++) step();
    req_valid = '0;
    check("s3_tx_n", tx_log.size() >= 9, 1'b1);
    if (tx_log.size() >= 9 && rs_log.size() >= 1) begin
      for (int k = 1; k < 8; k++)
        check("s3_b2b", tx_log[k].cyc, tx_log[0].cyc + k);
      check("s3_ninth", tx_log[8].cyc, rs_log[0].cyc + 1);
    end
    drain();

    // fairness with gaps
    do_reset();
    one_shot[0] = 1'b1;
    req_valid[3] = 1'b1;
    for (int k = 0; k < 24; k++) begin
      if (k % 4 == 0) begin
        req_valid[0] = 1'b1;
        acyc.push_back(cyc);
      end
      step();
    end
    req_valid = '0;
    n0 = 0;
    n3 = 0;
    foreach (tx_log[k]) begin
      if (tx_log[k].id == 0) begin
        if (n0 < acyc.size())
          check("s4_lat", tx_log[k].cyc - acyc[n0] <= 1, 1'b1);
        n0++;
      end
      if (tx_log[k].id == 3) n3++;
    end
    check("s4_n0", n0, 6);
    check("s4_n3", n3, MAX_OUT);
    drain();

    // simultaneous increment and decrement on requester 0
    do_reset();
    req_valid[0] = 1'b1;
    for (int k = 0; k < 5; k++) step();
    req_valid = '0;
    c0 = (tx_log.size() > 0) ? tx_log[0].cyc : cyc;
    check("s5_tx5", tx_log.size(), 5);
    while (cyc < c0 + LAT) step();
    one_shot[0] = 1'b1;
    req_valid[0] = 1'b1;
    step();
    check("s5_grant", last_tx, 4'b0001);
    check("s5_cnt", dut.cnt[0], 4'd5);
    drain();
    check("s5_res_n", rs_log.size(), 6);

    // reset while operations are in flight
    do_reset();
    c0 = cyc;
    req_valid = 4'b0011;
    for (int k = 0; k < 20 && tx_log.size() < 6; k++) step();
    req_valid = '0;
    check("s6_tx6", tx_log.size(), 6);
    while (cyc < c0 + 20) step();
    rst = 1'b1;
    req_valid = 4'b0100;
    step();
    rst = 1'b0;
    req_valid = '0;
    for (int k = 0; k < 60; k++) step();
    check("s6_flushed", rs_log.size(), 0);
    check("s6_busy", busy, 1'b0);
    one_shot[3] = 1'b1;
    req_valid[3] = 1'b1;
    step();
    check("s6_grant", last_tx, 4'b1000);
    drain();
    check("s6_res_n", rs_log.size(), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
